// File: rtl/vin_frequency_avg_pkg.sv
// rtl/vin_frequency_avg_pkg.sv - shared state type for the period averaging stage
package vin_frequency_avg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } avg_state_e;

endpackage

// File: rtl/vin_frequency_avg_tick.sv
// rtl/vin_frequency_avg_tick.sv - free-running prescaler producing the sample strobe
module vin_frequency_avg_tick #(
    parameter int SAMPLE_CNT = 250000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (SAMPLE_CNT > 2) ? $clog2(SAMPLE_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_CNT - 1);

    logic [CW-1:0] count;

    // Count 0..SAMPLE_CNT-1 and wrap; the strobe is decoded from the last count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/vin_frequency_avg.sv
// rtl/vin_frequency_avg.sv - moving average of the upstream period word over 2^AVG_LOG2 ticks
module vin_frequency_avg
    import vin_frequency_avg_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int AVG_LOG2   = 3,
    parameter int SAMPLE_CNT = 250000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] period_in,
    output logic [WIDTH-1:0] period_avg,
    output logic             avg_valid,
    output logic             sample_tick
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = WIDTH + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    avg_state_e          state, state_nxt;
    logic [SUM_W-1:0]    sum, sum_nxt;
    logic [AVG_LOG2-1:0] wr, wr_nxt;
    logic [FILL_W-1:0]   fill, fill_nxt;
    logic [WIDTH-1:0]    last_sample;
    logic                buf_we;
    logic [WIDTH-1:0]    buf_mem [DEPTH];
    logic [WIDTH-1:0]    oldest;
    logic                tick;

    vin_frequency_avg_tick #(
        .SAMPLE_CNT(SAMPLE_CNT)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign sample_tick = tick;
    // wr only moves at the edge after a tick, so this read is settled by the tick cycle
    assign oldest = buf_mem[wr];

    // Next state, running sum and pointers; everything holds except on a tick
    always_comb begin
        state_nxt = state;
        sum_nxt   = sum;
        wr_nxt    = wr;
        fill_nxt  = fill;
        buf_we    = 1'b0;
        if (tick) begin
            if (period_in == '0) begin
                state_nxt = ST_EMPTY;
                sum_nxt   = '0;
                wr_nxt    = '0;
                fill_nxt  = '0;
            end else begin
                buf_we = 1'b1;
                wr_nxt = wr + 1'b1;
                unique case (state)
                    ST_EMPTY: begin
                        sum_nxt   = SUM_W'(period_in);
                        fill_nxt  = FILL_W'(1);
                        state_nxt = ST_FILLING;
                    end
                    ST_FILLING: begin
                        sum_nxt  = sum + SUM_W'(period_in);
                        fill_nxt = fill + 1'b1;
                        if (fill == FILL_W'(DEPTH - 1)) begin
                            state_nxt = ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        sum_nxt = sum - SUM_W'(oldest) + SUM_W'(period_in);
                    end
                    default: begin
                        state_nxt = ST_EMPTY;
                        sum_nxt   = '0;
                        wr_nxt    = '0;
                        fill_nxt  = '0;
                        buf_we    = 1'b0;
                    end
                endcase
            end
        end
    end

    // State, sum, pointers and the most recent sample for fill-time pass-through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            sum         <= '0;
            wr          <= '0;
            fill        <= '0;
            last_sample <= '0;
        end else begin
            state <= state_nxt;
            sum   <= sum_nxt;
            wr    <= wr_nxt;
            fill  <= fill_nxt;
            if (buf_we) begin
                last_sample <= period_in;
            end
        end
    end

    // Ring buffer storage; stale contents are never read before the window is full
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr] <= period_in;
        end
    end

    // Output stage registered one cycle behind the sum/state update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_avg <= '0;
            avg_valid  <= 1'b0;
        end else begin
            unique case (state)
                ST_FILLING: begin
                    period_avg <= last_sample;
                    avg_valid  <= 1'b0;
                end
                ST_FULL: begin
                    period_avg <= sum[SUM_W-1:AVG_LOG2];
                    avg_valid  <= 1'b1;
                end
                default: begin
                    period_avg <= '0;
                    avg_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vin_frequency_avg.sv
// tb/tb_vin_frequency_avg.sv - randomized self-checking bench for vin_frequency_avg
module tb_vin_frequency_avg;

    localparam int W     = 32;
    localparam int L     = 2;
    localparam int SC    = 4;
    localparam int DEPTH = 1 << L;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] period_in = '0;
    logic [W-1:0] period_avg;
    logic         avg_valid;
    logic         sample_tick;

    vin_frequency_avg #(
        .WIDTH     (W),
        .AVG_LOG2  (L),
        .SAMPLE_CNT(SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .period_in  (period_in),
        .period_avg (period_avg),
        .avg_valid  (avg_valid),
        .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned edges;
    logic [W-1:0] win [$];
    logic [W:0]   lag1, lag2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {valid, avg} implied by the current window contents
    function automatic logic [W:0] model_out();
        longint unsigned s;
        if (win.size() == 0) return '0;
        if (win.size() < DEPTH) return {1'b0, win[win.size()-1]};
        s = 0;
        foreach (win[i]) s += win[i];
        return {1'b1, W'(s >> L)};
    endfunction

    function automatic void model_reset();
        edges = 0;
        win.delete();
        lag1 = '0;
        lag2 = '0;
    endfunction

    // One clock cycle: drive, check this cycle's outputs, apply the tick to the model
    task automatic cycle(input logic [W-1:0] v);
        logic tk;
        period_in = v;
        tk = ((edges % SC) == SC - 1);
        check("sample_tick", sample_tick, tk);
        check("period_avg", period_avg, lag2[W-1:0]);
        check("avg_valid", avg_valid, lag2[W]);
        if (tk) begin
            if (v == '0) begin
                win.delete();
            end else begin
                win.push_back(v);
                if (win.size() > DEPTH) void'(win.pop_front());
            end
        end
        lag2 = lag1;
        lag1 = model_out();
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    // Run until one tick has consumed sample s; other cycles carry s or junk
    task automatic tick_sample(input logic [W-1:0] s, input bit glitch);
        bit done;
        done = 1'b0;
        while (!done) begin
            if ((edges % SC) == SC - 1) begin
                cycle(s);
                done = 1'b1;
            end else begin
                cycle(glitch ? W'($urandom_range(1, 1000)) : s);
            end
        end
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [W-1:0] rs;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_avg", period_avg, '0);
        check("reset_valid", avg_valid, 1'b0);
        check("reset_tick", sample_tick, 1'b0);
        reset_release();

        // cadence and first pass-through value
        repeat (3) cycle(32'd100);
        cycle(32'd100);
        cycle(32'd100);
        check("first_pass", period_avg, 32'd100);
        check("first_valid", avg_valid, 1'b0);

        // fill then average
        tick_sample(32'd200, 1'b0);
        tick_sample(32'd300, 1'b0);
        tick_sample(32'd400, 1'b0);
        cycle(32'd400);
        check("avg_250", period_avg, 32'd250);
        check("valid_full", avg_valid, 1'b1);

        // sliding window and saturation of the arithmetic
        tick_sample(32'd500, 1'b0);
        cycle(32'd500);
        check("avg_350", period_avg, 32'd350);
        repeat (DEPTH) tick_sample(32'hFFFF_FFFF, 1'b0);
        cycle(32'hFFFF_FFFF);
        check("avg_max", period_avg, 32'hFFFF_FFFF);

        // timeout then refill
        tick_sample(32'd0, 1'b0);
        cycle(32'd0);
        check("timeout_avg", period_avg, 32'd0);
        check("timeout_valid", avg_valid, 1'b0);
        tick_sample(32'd80, 1'b0);
        cycle(32'd80);
        check("refill_avg", period_avg, 32'd80);
        check("refill_valid", avg_valid, 1'b0);

        // async reset mid-fill, away from any clock edge
        tick_sample(32'd90, 1'b0);
        cycle(32'd90);
        #2 rst_n = 1'b0;
        #1;
        check("async_avg", period_avg, '0);
        check("async_valid", avg_valid, 1'b0);
        check("async_tick", sample_tick, 1'b0);
        @(negedge clk);
        reset_release();
        for (int i = 0; i < DEPTH; i++) begin
            tick_sample(32'd60 + 32'(i), 1'b1);
        end
        repeat (2) cycle(32'd5);

        // between-tick glitching
        repeat (6) tick_sample(32'd50, 1'b1);
        cycle(32'd7);
        check("glitch_avg", period_avg, 32'd50);

        // randomized run with occasional timeouts
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) rs = '0;
            else if ($urandom_range(0, 3) == 0) rs = $urandom;
            else rs = W'($urandom_range(1, 5000));
            tick_sample(rs, 1'b1);
        end
        repeat (3) cycle(32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
